// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types.
package cpu_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/shift_left_core.sv
// Pure combinational logical left shifter with shifted-out bits and overflow flag.
module shift_left_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SHAMT = 1
) (
    input  logic [WIDTH-1:0]                      beforeShift,
    output logic [WIDTH-1:0]                      afterShift,
    output logic [((SHAMT > 0) ? SHAMT : 1)-1:0]  shifted_out,
    output logic                                  overflow
);

    assign afterShift = beforeShift << SHAMT;

    // A zero shift loses nothing and cannot change the sign, so the
    // shifted-out port degenerates to a single constant-zero bit.
    generate
        if (SHAMT == 0) begin : g_no_shift
            assign shifted_out = 1'b0;
            assign overflow    = 1'b0;
        end else begin : g_shift
            assign shifted_out = beforeShift[WIDTH-1 -: SHAMT];
            assign overflow    = (|shifted_out) | (afterShift[WIDTH-1] ^ beforeShift[WIDTH-1]);
        end
    endgenerate

endmodule

// File: rtl/shift_left_unit.sv
// Left-shift unit: combinational result plus a one-cycle registered copy with valid.
module shift_left_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SHAMT = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WIDTH-1:0]                      beforeShift,
    input  logic                                  in_valid,
    output logic [WIDTH-1:0]                      afterShift,
    output logic [((SHAMT > 0) ? SHAMT : 1)-1:0]  shifted_out,
    output logic                                  overflow,
    output logic [WIDTH-1:0]                      after_q,
    output logic [((SHAMT > 0) ? SHAMT : 1)-1:0]  shifted_out_q,
    output logic                                  overflow_q,
    output logic                                  out_valid
);

    shift_left_core #(
        .WIDTH (WIDTH),
        .SHAMT (SHAMT)
    ) u_core (
        .beforeShift (beforeShift),
        .afterShift  (afterShift),
        .shifted_out (shifted_out),
        .overflow    (overflow)
    );

    // Data registers only load on valid so consumers see the last accepted result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            after_q       <= '0;
            shifted_out_q <= '0;
            overflow_q    <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                after_q       <= afterShift;
                shifted_out_q <= shifted_out;
                overflow_q    <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_shift_left_unit.sv
// Scoreboard bench for shift_left_unit: directed vectors plus a short random sweep.
module tb_shift_left_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] beforeShift = 16'h0000;
    logic        in_valid = 1'b0;
    logic [15:0] afterShift;
    logic [0:0]  shifted_out;
    logic        overflow;
    logic [15:0] after_q;
    logic [0:0]  shifted_out_q;
    logic        overflow_q;
    logic        out_valid;

    typedef struct packed {
        logic [15:0] after;
        logic        so;
        logic        ov;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          errors = 0;
    logic [15:0] last_after = 16'h0000;

    shift_left_unit #(.WIDTH(16), .SHAMT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .beforeShift   (beforeShift),
        .in_valid      (in_valid),
        .afterShift    (afterShift),
        .shifted_out   (shifted_out),
        .overflow      (overflow),
        .after_q       (after_q),
        .shifted_out_q (shifted_out_q),
        .overflow_q    (overflow_q),
        .out_valid     (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one vector at the falling edge, check the combinational outputs
    // right away and queue the registered expectation if it will be captured.
    task automatic drive(input logic [15:0] v, input logic vld,
                         input logic [15:0] ea, input logic eso, input logic eov);
        exp_t e;
        @(negedge clk);
        beforeShift = v;
        in_valid    = vld;
        #1;
        check("comb_after", afterShift, ea);
        check("comb_so", {15'd0, shifted_out}, {15'd0, eso});
        check("comb_ov", {15'd0, overflow}, {15'd0, eov});
        $display("[TB] drive %h vld=%0d -> after=%h so=%0d ov=%0d", v, vld, afterShift, shifted_out, overflow);
        if (vld && !rst) begin
            e.after = ea; e.so = eso; e.ov = eov;
            sb_q.push_back(e);
            last_after = ea;
        end
    endtask

    // Monitor: pop and compare whenever the registered stage presents a result.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_out: out_valid=1 with empty scoreboard, after_q=%h", after_q);
            end else begin
                e = sb_q.pop_front();
                check("reg_after", after_q, e.after);
                check("reg_so", {15'd0, shifted_out_q}, {15'd0, e.so});
                check("reg_ov", {15'd0, overflow_q}, {15'd0, e.ov});
                $display("[TB] capture after_q=%h so_q=%0d ov_q=%0d", after_q, shifted_out_q, overflow_q);
            end
        end
    end

    initial begin
        logic [15:0] v;
        logic [15:0] ea;
        // Reset held: combinational path live, registered path cleared.
        rst = 1'b1;
        beforeShift = 16'h0021;
        in_valid = 1'b1;
        #1;
        check("rst_comb_after", afterShift, 16'h0042);
        check("rst_after_q", after_q, 16'h0000);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_after_q", after_q, 16'h0000);
        check("rst_hold_valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;

        drive(16'h0021, 1'b1, 16'h0042, 1'b0, 1'b0);
        drive(16'h7676, 1'b1, 16'hECEC, 1'b0, 1'b1);
        drive(16'h1234, 1'b1, 16'h2468, 1'b0, 1'b0);
        drive(16'h8000, 1'b1, 16'h0000, 1'b1, 1'b1);
        drive(16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 1'b1);
        drive(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
        drive(16'h4000, 1'b1, 16'h8000, 1'b0, 1'b1);

        // Idle edges with changing operand: data registers must hold.
        drive(16'hAAAA, 1'b0, 16'h5554, 1'b1, 1'b1);
        drive(16'h5555, 1'b0, 16'hAAAA, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("idle_valid", {15'd0, out_valid}, 16'd0);
        check("idle_hold", after_q, last_after);

        // Mid-operation reset between edges.
        drive(16'h0123, 1'b1, 16'h0246, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_after_q", after_q, 16'h0000);
        check("async_so_q", {15'd0, shifted_out_q}, 16'd0);
        check("async_ov_q", {15'd0, overflow_q}, 16'd0);
        check("async_valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            v  = 16'($urandom);
            ea = {v[14:0], 1'b0};
            drive(v, 1'($urandom_range(0, 1)), ea, v[15], v[15] | (v[14] ^ v[15]));
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
